// File: rtl/lsu_pkg.sv
// Shared configuration for the load/store stage: bus widths, LSU type
// codes, FSM state encoding and small type-classification helpers.
package lsu_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ARGS_WIDTH = 4;
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   localparam logic [ARGS_WIDTH-1:0] LSU_NONE = 4'd0;
   localparam logic [ARGS_WIDTH-1:0] LSU_LB   = 4'd1;
   localparam logic [ARGS_WIDTH-1:0] LSU_LH   = 4'd2;
   localparam logic [ARGS_WIDTH-1:0] LSU_LW   = 4'd3;
   localparam logic [ARGS_WIDTH-1:0] LSU_LBU  = 4'd4;
   localparam logic [ARGS_WIDTH-1:0] LSU_LHU  = 4'd5;
   localparam logic [ARGS_WIDTH-1:0] LSU_SB   = 4'd6;
   localparam logic [ARGS_WIDTH-1:0] LSU_SH   = 4'd7;
   localparam logic [ARGS_WIDTH-1:0] LSU_SW   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   function automatic logic lsu_is_load(input logic [ARGS_WIDTH-1:0] t);
      return (t == LSU_LB) || (t == LSU_LH) || (t == LSU_LW) ||
             (t == LSU_LBU) || (t == LSU_LHU);
   endfunction

   function automatic logic lsu_is_store(input logic [ARGS_WIDTH-1:0] t);
      return (t == LSU_SB) || (t == LSU_SH) || (t == LSU_SW);
   endfunction

   function automatic logic lsu_is_half(input logic [ARGS_WIDTH-1:0] t);
      return (t == LSU_LH) || (t == LSU_LHU) || (t == LSU_SH);
   endfunction

   function automatic logic lsu_is_word(input logic [ARGS_WIDTH-1:0] t);
      return (t == LSU_LW) || (t == LSU_SW);
   endfunction

   // True when the access does not sit on its natural boundary.
   function automatic logic lsu_misaligned(input logic [ARGS_WIDTH-1:0] t,
                                           input logic [1:0]            lo);
      return (lsu_is_half(t) && lo[0]) || (lsu_is_word(t) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store stage: store data
// replication and byte-enable generation, plus load byte/half extraction
// with sign or zero extension. Holds no state.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [ARGS_WIDTH-1:0] lsu_type,
   input  logic [1:0]            byte_off,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] load_word,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [MASK_WIDTH-1:0] wmask,
   output logic [DATA_WIDTH-1:0] load_res
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store path: replicate the source across lanes, enable only the target bytes.
   always_comb begin
      wdata = '0;
      wmask = '0;
      case (lsu_type)
         LSU_SB: begin
            wdata = {4{store_data[7:0]}};
            wmask = MASK_WIDTH'(4'b0001) << byte_off;
         end
         LSU_SH: begin
            wdata = {2{store_data[15:0]}};
            wmask = MASK_WIDTH'(4'b0011) << byte_off;
         end
         LSU_SW: begin
            wdata = store_data;
            wmask = '1;
         end
         default: begin
            wdata = '0;
            wmask = '0;
         end
      endcase
   end

   // Load path: pick the addressed byte/half out of the word and extend it.
   always_comb begin
      byte_sel = load_word[{byte_off, 3'b000} +: 8];
      half_sel = load_word[{byte_off[1], 4'b0000} +: 16];
      load_res = '0;
      case (lsu_type)
         LSU_LB:  load_res = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         LSU_LBU: load_res = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         LSU_LH:  load_res = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         LSU_LHU: load_res = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         LSU_LW:  load_res = load_word;
         default: load_res = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store stage. Takes one operation at a time from execute, runs a
// single request/response transaction on the data-memory port and hands
// the (extended) load data or pass-through ALU result to write-back.
//
// Handshake: a transfer on any valid/ready pair happens in the cycle where
// both are high at the rising clock edge; a valid, once raised, holds its
// payload stable until that transfer. The memory response has no ready and
// is consumed only in WAIT.
//
// Build option: define LSU_MISALIGN_CHK_EN to flag misaligned half/word
// accesses (fault raised, memory skipped). Without it the low address bits
// are forced to natural alignment and o_lsu_fault is tied low.
module lsu
   import lsu_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sys_valid,
   output logic                  o_sys_ready,
   input  logic [ARGS_WIDTH-1:0] i_idu_ctr_lsu_type,
   input  logic [DATA_WIDTH-1:0] i_exu_res,
   input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
   output logic                  o_ram_req_valid,
   input  logic                  i_ram_req_ready,
   output logic                  o_ram_req_wr,
   output logic [ADDR_WIDTH-1:0] o_ram_req_addr,
   output logic [DATA_WIDTH-1:0] o_ram_req_wdata,
   output logic [MASK_WIDTH-1:0] o_ram_req_wmask,
   input  logic                  i_ram_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_ram_rsp_rdata,
   output logic                  o_sys_valid,
   input  logic                  i_sys_ready,
   output logic [DATA_WIDTH-1:0] o_lsu_res,
   output logic                  o_lsu_fault,
   output logic [1:0]            o_dbg_state
);

   lsu_state_e            state_q;
   logic [ARGS_WIDTH-1:0] type_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  req_valid_q;
   logic                  sys_valid_q;

   logic                  accept;
   logic                  is_mem_op;
   logic [ADDR_WIDTH-1:0] addr_eff;
   logic [DATA_WIDTH-1:0] wdata_w;
   logic [MASK_WIDTH-1:0] wmask_w;
   logic [DATA_WIDTH-1:0] load_res_w;

`ifdef LSU_MISALIGN_CHK_EN
   logic                  fault_q;
   logic                  misaligned_in;
`endif

   assign accept    = i_sys_valid && (state_q == ST_IDLE);
   assign is_mem_op = lsu_is_load(i_idu_ctr_lsu_type) || lsu_is_store(i_idu_ctr_lsu_type);

`ifdef LSU_MISALIGN_CHK_EN
   assign misaligned_in = lsu_misaligned(i_idu_ctr_lsu_type, i_exu_res[1:0]);
`endif

   // Effective address; without the checker, low bits snap to the access size.
   always_comb begin
      addr_eff = i_exu_res[ADDR_WIDTH-1:0];
`ifndef LSU_MISALIGN_CHK_EN
      if (lsu_is_half(i_idu_ctr_lsu_type)) begin
         addr_eff[0] = 1'b0;
      end else if (lsu_is_word(i_idu_ctr_lsu_type)) begin
         addr_eff[1:0] = 2'b00;
      end
`endif
   end

   lsu_align u_align (
      .lsu_type   (type_q),
      .byte_off   (addr_q[1:0]),
      .store_data (rs2_q),
      .load_word  (i_ram_rsp_rdata),
      .wdata      (wdata_w),
      .wmask      (wmask_w),
      .load_res   (load_res_w)
   );

   // Main FSM: accept, issue one memory transaction, then hold result for write-back.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         type_q      <= LSU_NONE;
         addr_q      <= '0;
         rs2_q       <= '0;
         res_q       <= '0;
         req_valid_q <= 1'b0;
         sys_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  type_q <= i_idu_ctr_lsu_type;
                  addr_q <= addr_eff;
                  rs2_q  <= i_idu_rs2_data;
`ifdef LSU_MISALIGN_CHK_EN
                  fault_q <= misaligned_in;
                  if (misaligned_in) begin
                     res_q       <= '0;
                     sys_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else
`endif
                  if (is_mem_op) begin
                     req_valid_q <= 1'b1;
                     state_q     <= ST_REQ;
                  end else begin
                     res_q       <= i_exu_res;
                     sys_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end
               end
            end
            ST_REQ: begin
               if (i_ram_req_ready) begin
                  req_valid_q <= 1'b0;
                  if (lsu_is_store(type_q)) begin
                     res_q       <= '0;
                     sys_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (i_ram_rsp_valid) begin
                  res_q       <= load_res_w;
                  sys_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_sys_ready) begin
                  sys_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_valid_q <= 1'b0;
               sys_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Memory port payload is driven only while a request is outstanding.
   always_comb begin
      o_ram_req_valid = req_valid_q;
      o_ram_req_wr    = req_valid_q && lsu_is_store(type_q);
      o_ram_req_addr  = req_valid_q ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
      o_ram_req_wdata = req_valid_q ? wdata_w : '0;
      o_ram_req_wmask = req_valid_q ? wmask_w : '0;
   end

   assign o_sys_ready = (state_q == ST_IDLE);
   assign o_sys_valid = sys_valid_q;
   assign o_lsu_res   = res_q;
   assign o_dbg_state = state_q;

`ifdef LSU_MISALIGN_CHK_EN
   assign o_lsu_fault = fault_q;
`else
   assign o_lsu_fault = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Bench for the load/store stage: a vector table run through one driver
// task, a reset-during-WAIT sequence, and a short randomised tail.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_sys_valid;
   logic        o_sys_ready;
   logic [3:0]  i_idu_ctr_lsu_type;
   logic [31:0] i_exu_res;
   logic [31:0] i_idu_rs2_data;
   logic        o_ram_req_valid;
   logic        i_ram_req_ready;
   logic        o_ram_req_wr;
   logic [31:0] o_ram_req_addr;
   logic [31:0] o_ram_req_wdata;
   logic [3:0]  o_ram_req_wmask;
   logic        i_ram_rsp_valid;
   logic [31:0] i_ram_rsp_rdata;
   logic        o_sys_valid;
   logic        i_sys_ready;
   logic [31:0] o_lsu_res;
   logic        o_lsu_fault;
   logic [1:0]  o_dbg_state;

   always #5 clk = ~clk;

   lsu dut (
      .i_clk              (clk),
      .i_rst              (i_rst),
      .i_sys_valid        (i_sys_valid),
      .o_sys_ready        (o_sys_ready),
      .i_idu_ctr_lsu_type (i_idu_ctr_lsu_type),
      .i_exu_res          (i_exu_res),
      .i_idu_rs2_data     (i_idu_rs2_data),
      .o_ram_req_valid    (o_ram_req_valid),
      .i_ram_req_ready    (i_ram_req_ready),
      .o_ram_req_wr       (o_ram_req_wr),
      .o_ram_req_addr     (o_ram_req_addr),
      .o_ram_req_wdata    (o_ram_req_wdata),
      .o_ram_req_wmask    (o_ram_req_wmask),
      .i_ram_rsp_valid    (i_ram_rsp_valid),
      .i_ram_rsp_rdata    (i_ram_rsp_rdata),
      .o_sys_valid        (o_sys_valid),
      .i_sys_ready        (i_sys_ready),
      .o_lsu_res          (o_lsu_res),
      .o_lsu_fault        (o_lsu_fault),
      .o_dbg_state        (o_dbg_state)
   );

   typedef struct {
      logic [3:0]  typ;
      logic [31:0] exu;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          req_lat;
      int          rsp_gap;
      int          wb_hold;
      logic        exp_req;
      logic        exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wmask;
      logic [31:0] exp_res;
      logic        exp_fault;
   } vec_t;

   vec_t        vecs[$];
   logic [32:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic vec_t mk(logic [3:0] typ, logic [31:0] exu, logic [31:0] rs2,
                               logic [31:0] rdata, int req_lat, int rsp_gap, int wb_hold,
                               logic exp_req, logic exp_wr, logic [31:0] exp_addr,
                               logic [31:0] exp_wdata, logic [3:0] exp_wmask,
                               logic [31:0] exp_res, logic exp_fault);
      vec_t v;
      v.typ = typ; v.exu = exu; v.rs2 = rs2; v.rdata = rdata;
      v.req_lat = req_lat; v.rsp_gap = rsp_gap; v.wb_hold = wb_hold;
      v.exp_req = exp_req; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
      v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
      v.exp_res = exp_res; v.exp_fault = exp_fault;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one operation and play memory and write-back around it.
   task automatic run_vec(input vec_t v, input string tag);
      int          exp_done;
      int          req_first;
      int          a_cyc;
      bit          req_seen;
      bit          req_acc;
      bit          done;
      logic [32:0] e;
      req_seen = 0; req_acc = 0; done = 0; req_first = 0; a_cyc = 0;
      if (!v.exp_req)    exp_done = 1;
      else if (v.exp_wr) exp_done = 2 + v.req_lat;
      else               exp_done = 2 + v.req_lat + v.rsp_gap;

      @(negedge clk);
      check($sformatf("%s idle_ready", tag), 32'(o_sys_ready), 32'd1);
      i_sys_valid        = 1'b1;
      i_idu_ctr_lsu_type = v.typ;
      i_exu_res          = v.exu;
      i_idu_rs2_data     = v.rs2;
      exp_q.push_back({v.exp_fault, v.exp_res});

      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         i_sys_valid        = 1'b0;
         i_idu_ctr_lsu_type = 4'($urandom_range(0, 8));
         i_exu_res          = $urandom();
         i_idu_rs2_data     = $urandom();
         i_ram_req_ready    = 1'b0;
         i_ram_rsp_valid    = 1'b0;
         i_ram_rsp_rdata    = $urandom();
         if (!req_acc || v.exp_wr || (cyc > a_cyc + v.rsp_gap))
            i_ram_rsp_valid = 1'($urandom_range(0, 1));

         if (o_ram_req_valid) begin
            if (!v.exp_req) begin
               check($sformatf("%s unexpected_req", tag), 32'(o_ram_req_valid), 32'd0);
            end else begin
               if (!req_seen) begin
                  req_seen  = 1;
                  req_first = cyc;
                  check($sformatf("%s req_cycle", tag), 32'(cyc), 32'd1);
               end
               check($sformatf("%s addr", tag), o_ram_req_addr, v.exp_addr);
               check($sformatf("%s wr", tag), 32'(o_ram_req_wr), 32'(v.exp_wr));
               check($sformatf("%s wmask", tag), 32'(o_ram_req_wmask), 32'(v.exp_wmask));
               if (v.exp_wr)
                  check($sformatf("%s wdata", tag), o_ram_req_wdata, v.exp_wdata);
               if (cyc - req_first >= v.req_lat) begin
                  i_ram_req_ready = 1'b1;
                  a_cyc           = cyc;
                  req_acc         = 1;
               end
            end
         end

         if (req_acc && !v.exp_wr && cyc == a_cyc + v.rsp_gap) begin
            i_ram_rsp_valid = 1'b1;
            i_ram_rsp_rdata = v.rdata;
         end

         if (o_sys_valid) begin
            check($sformatf("%s latency", tag), 32'(cyc), 32'(exp_done));
            check($sformatf("%s busy_ready", tag), 32'(o_sys_ready), 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL %s: unexpected result %h", tag, o_lsu_res);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("%s res", tag), o_lsu_res, e[31:0]);
               check($sformatf("%s fault", tag), 32'(o_lsu_fault), 32'(e[32]));
               i_ram_rsp_valid = 1'b0;
               for (int h = 0; h < v.wb_hold; h++) begin
                  @(negedge clk);
                  check($sformatf("%s hold_valid", tag), 32'(o_sys_valid), 32'd1);
                  check($sformatf("%s hold_res", tag), o_lsu_res, e[31:0]);
                  check($sformatf("%s hold_ready", tag), 32'(o_sys_ready), 32'd0);
               end
            end
            i_sys_ready = 1'b1;
            @(negedge clk);
            i_sys_ready     = 1'b0;
            i_ram_rsp_valid = 1'b0;
            check($sformatf("%s after_valid", tag), 32'(o_sys_valid), 32'd0);
            check($sformatf("%s after_ready", tag), 32'(o_sys_ready), 32'd1);
            done = 1;
         end else if (cyc < exp_done) begin
            check($sformatf("%s busy", tag), 32'(o_sys_ready), 32'd0);
         end
      end

      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no result within cycle budget", tag);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      i_ram_rsp_valid = 1'b0;
      i_ram_req_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      i_rst = 1'b1;
      i_sys_valid = 1'b0; i_idu_ctr_lsu_type = '0; i_exu_res = '0; i_idu_rs2_data = '0;
      i_ram_req_ready = 1'b0; i_ram_rsp_valid = 1'b0; i_ram_rsp_rdata = '0; i_sys_ready = 1'b0;

      // Vector table
      vecs.push_back(mk(LSU_NONE, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0,
                        1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_1234, 1'b0));
      vecs.push_back(mk(LSU_SB, 32'h8000_0003, 32'hAABB_CCDD, 32'h0, 3, 0, 0,
                        1'b1, 1'b1, 32'h8000_0000, 32'hDDDD_DDDD, 4'b1000, 32'h0, 1'b0));
      vecs.push_back(mk(LSU_LB, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 1, 0,
                        1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b0));
      vecs.push_back(mk(LSU_LBU, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 1, 0,
                        1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0080, 1'b0));
`ifdef LSU_MISALIGN_CHK_EN
      vecs.push_back(mk(LSU_LH, 32'h8000_0001, 32'h0, 32'h1234_8765, 0, 2, 1,
                        1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1));
`else
      vecs.push_back(mk(LSU_LH, 32'h8000_0001, 32'h0, 32'h1234_8765, 0, 2, 1,
                        1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_8765, 1'b0));
`endif
      vecs.push_back(mk(LSU_LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 3, 5,
                        1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(mk(LSU_SH, 32'h0000_0102, 32'h1111_BEEF, 32'h0, 0, 0, 0,
                        1'b1, 1'b1, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100, 32'h0, 1'b0));
      vecs.push_back(mk(LSU_SW, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 2, 0, 1,
                        1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0));
      vecs.push_back(mk(LSU_LHU, 32'h0000_0302, 32'h0, 32'h9ABC_0000, 0, 1, 0,
                        1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_9ABC, 1'b0));
      vecs.push_back(mk(LSU_LH, 32'h0000_0302, 32'h0, 32'h9ABC_0000, 0, 1, 0,
                        1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'hFFFF_9ABC, 1'b0));
      vecs.push_back(mk(LSU_LB, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 2, 0,
                        1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_007F, 1'b0));
`ifdef LSU_MISALIGN_CHK_EN
      vecs.push_back(mk(LSU_SW, 32'h0000_0006, 32'h0102_0304, 32'h0, 0, 0, 0,
                        1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1));
`else
      vecs.push_back(mk(LSU_SW, 32'h0000_0006, 32'h0102_0304, 32'h0, 0, 0, 0,
                        1'b1, 1'b1, 32'h0000_0004, 32'h0102_0304, 4'b1111, 32'h0, 1'b0));
`endif
      vecs.push_back(mk(LSU_SB, 32'h0000_0001, 32'h0000_00A5, 32'h0, 0, 0, 0,
                        1'b1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0));
      vecs.push_back(mk(LSU_NONE, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 2,
                        1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0));

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_valid", 32'(o_ram_req_valid), 32'd0);
      check("rst_sys_valid", 32'(o_sys_valid), 32'd0);
      check("rst_res", o_lsu_res, 32'h0);
      check("rst_fault", 32'(o_lsu_fault), 32'd0);
      check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(o_sys_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset pulsed while a load waits for its response
      @(negedge clk);
      i_sys_valid = 1'b1; i_idu_ctr_lsu_type = LSU_LW; i_exu_res = 32'h0000_0040;
      @(negedge clk);
      i_sys_valid = 1'b0;
      check("rw_req_valid", 32'(o_ram_req_valid), 32'd1);
      i_ram_req_ready = 1'b1;
      @(negedge clk);
      i_ram_req_ready = 1'b0;
      check("rw_state_wait", 32'(o_dbg_state), 32'(ST_WAIT));
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      check("rw_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
      check("rw_ready", 32'(o_sys_ready), 32'd1);
      check("rw_req_valid0", 32'(o_ram_req_valid), 32'd0);
      check("rw_sys_valid0", 32'(o_sys_valid), 32'd0);
      check("rw_res0", o_lsu_res, 32'h0);
      check("rw_addr0", o_ram_req_addr, 32'h0);
      check("rw_wmask0", 32'(o_ram_req_wmask), 32'd0);
      i_ram_rsp_valid = 1'b1; i_ram_rsp_rdata = 32'h5555_AAAA;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rw_late_rsp_valid", 32'(o_sys_valid), 32'd0);
         check("rw_late_rsp_res", o_lsu_res, 32'h0);
      end
      i_ram_rsp_valid = 1'b0;

      // Randomised tail: pass-through and aligned word loads with random timing
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = $urandom();
         d = $urandom();
         if ($urandom_range(0, 1) == 0) begin
            v = mk(LSU_NONE, a, $urandom(), 32'h0, 0, 0, $urandom_range(0, 3),
                   1'b0, 1'b0, 32'h0, 32'h0, 4'h0, a, 1'b0);
         end else begin
            a[1:0] = 2'b00;
            v = mk(LSU_LW, a, $urandom(), d, $urandom_range(0, 4), $urandom_range(1, 4),
                   $urandom_range(0, 3), 1'b1, 1'b0, a, 32'h0, 4'h0, d, 1'b0);
         end
         run_vec(v, $sformatf("rnd%0d", i));
      end

      if (exp_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: %0d results never seen", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
